// File: rtl/imm_gen_stage_pkg.sv
// RISC-V encoding constants and the shared types of the immediate-generation stage.
// Both packages are pure declarations; nothing here holds state.
package riscv;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SRX    = 3'b101;
endpackage

package core;
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } formats_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 32;

    // Max-width entry for consumers outside the stage; users truncate to their XLEN/TAG_W.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        formats_t             fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;
endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle between fetch, the immediate stage and decode/issue.
// slave is the stage side, master is the producer/consumer side.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       instr_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   imm_o;
    core::formats_t    fmt_o;
    logic              illegal_o;
    logic [TAG_W-1:0]  tag_o;

    modport slave (
        input  in_valid_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    modport master (
        output in_valid_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational opcode-driven immediate decoder; zero latency, no handshake.
// Format comes from the opcode alone; shifts carry a zero-extended shamt.
module imm_decode
    import riscv::*;
    import core::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output formats_t        fmt_o,
    output logic            illegal_o
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

    assign imm_i = XLEN'($signed(instr_i[31:20]));
    assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode)
            OP: fmt_o = FMT_R;
            OP_IMM: begin
                fmt_o = FMT_I;
                if (!is_shift) begin
                    imm_o = imm_i;
                end else if (XLEN == 64) begin
                    imm_o = XLEN'(instr_i[25:20]);
                end else begin
                    imm_o     = XLEN'(instr_i[24:20]);
                    illegal_o = instr_i[25];
                end
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt_o = FMT_I;
                    if (!is_shift) begin
                        imm_o = imm_i;
                    end else begin
                        // Word shifts are 5-bit; bit 25 set is an out-of-range shamt.
                        imm_o     = XLEN'(instr_i[24:20]);
                        illegal_o = instr_i[25];
                    end
                end else begin
                    illegal_o = 1'b1;
                end
            end
            LOAD, JALR, MISC_MEM, SYSTEM: begin
                fmt_o = FMT_I;
                imm_o = imm_i;
            end
            STORE: begin
                fmt_o = FMT_S;
                imm_o = imm_s;
            end
            BRANCH: begin
                fmt_o = FMT_B;
                imm_o = imm_b;
            end
            LUI, AUIPC: begin
                fmt_o = FMT_U;
                imm_o = imm_u;
            end
            JAL: begin
                fmt_o = FMT_J;
                imm_o = imm_j;
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage with a 2-entry skid buffer; 1-cycle latency, 1/cycle throughput.
// in_ready_o depends only on occupancy, so out_ready_i has no combinational path upstream.
module imm_gen_stage
    import core::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    imm_gen_stage_if.slave  bus
);
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        formats_t         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam entry_t RST_ENT = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

    logic [XLEN-1:0] dec_imm;
    formats_t        dec_fmt;
    logic            dec_illegal;
    entry_t          dec_ent;
    entry_t          head, skid;
    occ_t            occ;
    logic            accept, emit;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (bus.instr_i),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    assign dec_ent = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: bus.tag_i};
    assign accept  = bus.in_valid_i && bus.in_ready_o;
    assign emit    = bus.out_valid_o && bus.out_ready_i;

    // head always holds the oldest entry and drives the outputs; skid is only used when FULL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ  <= OCC_EMPTY;
            head <= RST_ENT;
            skid <= RST_ENT;
        end else if (flush_i) begin
            occ <= OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        head <= dec_ent;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && emit) begin
                        head <= dec_ent;
                    end else if (accept) begin
                        skid <= dec_ent;
                        occ  <= OCC_FULL;
                    end else if (emit) begin
                        occ  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (emit) begin
                        head <= skid;
                        occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    assign bus.in_ready_o  = (occ != OCC_FULL);
    assign bus.out_valid_o = (occ != OCC_EMPTY);
    assign bus.imm_o       = head.imm;
    assign bus.fmt_o       = head.fmt;
    assign bus.illegal_o   = head.illegal;
    assign bus.tag_o       = head.tag;
endmodule
